dmem_sized: RTL and testbench
=============================

Name: dmem_sized

Overview:
Parametrised data memory, successor to the single-cycle word dmem. Adds byte/half/word access sizes with byte-lane writes and sign/zero-extended loads, plus misalignment and range fault detection. Read latency is configurable, with a valid/ready request and response handshake. Sits between the CPU MEM stage and the backing RAM array.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; power of two, at least 4.
READ_LATENCY, 1, cycles from request accept to response valid; legal range 1..4.
ADDR_W, 32, request address width in bits; byte addressed.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  request accepted when req_valid && req_ready at a rising edge.
RW  in  1  1 = store, 0 = load.
address  in  ADDR_W  byte address.
size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
unsigned_ld  in  1  1 = zero-extend load, 0 = sign-extend load.
wdata  in  32  store data, LSB-justified.
rsp_valid  out  1  response present.
rsp_ready  in  1  consumer accepts response.
rdata  out  32  extended load data; 0 for stores and faults.
fault  out  1  response corresponds to a faulting request.

Behaviour:
- Reset (async assert): all pipeline valid bits cleared; rsp_valid=0, rdata=0, fault=0, req_ready=0 while rst is high. req_ready=1 on the first edge after release when the pipeline is not stalled. RAM contents are not reset.
- Pipeline: READ_LATENCY stages, each holding valid, RW, lane offset, size, unsigned_ld and fault. The final stage drives rsp_*.
- Every accepted request (load, store or fault) yields exactly one response, exactly READ_LATENCY cycles after accept when unstalled. Responses are returned in order.
- Stall: if rsp_valid && !rsp_ready, the whole pipeline holds and req_ready=0. req_ready = !(rsp_valid && !rsp_ready). Stage contents and rdata are held stable under stall.
- Fault conditions are evaluated at accept:
  - size==11;
  - half with address[0]=1;
  - word with address[1:0]!=0;
  - address >= 4*DEPTH_WORDS.
  A faulting request performs no RAM write and responds with fault=1, rdata=0.
- Store: the RAM is written at the accept edge.
  - Byte enables: byte → 1 lane at address[1:0], data wdata[7:0] replicated; half → lanes {a1,a1+1} with a1 = address[1]*2; word → all 4 lanes.
  - Store response: rdata=0, fault=0.
- Load: the word is read at index address[log2(DEPTH_WORDS)+1:2].
  - Lane select uses the registered offset.
  - Byte extends bit 7 of the selected lane; half extends bit 15 of the selected half; unsigned_ld forces zero extension.
  - Word ignores unsigned_ld.
- Read-after-write: a load accepted the cycle after a store to the same word returns the post-store data. There is no same-cycle conflict, since there is a single request port.
- Address bits above the range check are not aliased: an out-of-range address faults and never wraps.
- Reset mid-operation: in-flight responses are discarded. A store accepted before the reset edge remains written.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL;
  - the stage struct (valid, rw, off[1:0], size, uns, fault);
  - the function computing the 4-bit byte enable from size and offset.
- Sub-module dmem_load_align is purely combinational. It takes the raw word, offset, size and unsigned flag and produces the extended rdata. It is instantiated once at the final stage.

Test Plan:
- Word store/load: SW 0xABCDEF00 @0x0, then LW @0x0 → rsp_valid READ_LATENCY cycles later, rdata=0xABCDEF00, fault=0.
- Byte store and lane extension:
  - SW 0xFFFFFFFF @0x4, SB 0x12 @0x6, LW @0x4 → 0xFF12FFFF.
  - LB @0x6 → 0x00000012; LB @0x7 → 0xFFFFFFFF; LBU @0x7 → 0x000000FF.
- Half lanes and extension: SH 0x8001 @0xA, then LH @0xA → 0xFFFF8001; LHU @0xA → 0x00008001.
- Faults:
  - LW @0x2 → fault=1, rdata=0.
  - SH @0x5 → fault=1, and a subsequent LW @0x4 is unchanged.
  - LW @4*DEPTH_WORDS → fault=1.
  - size=11 → fault=1.
- Backpressure: hold rsp_ready=0 with back-to-back loads → req_ready drops the same cycle rsp_valid rises. rdata holds stable; after release, responses arrive in order with no loss or duplication.
- Reset mid-flight: assert rst with 2 loads in flight → rsp_valid=0 immediately (async). After release there are no stale responses, and stored data persists.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory.
//   size_e   : access size encoding as carried on the size port
//   stage_t  : per-stage pipeline record (valid, rw, lane offset, size, unsigned, fault)
//   byte_en  : 4-bit byte-lane write enable from size and byte offset
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  typedef struct packed {
    logic       valid;
    logic       rw;
    logic [1:0] off;
    size_e      size;
    logic       uns;
    logic       fault;
  } stage_t;

  function automatic logic [3:0] byte_en(size_e sz, logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    unique case (sz)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Combinational load lane select and sign/zero extension.
//   word : raw 32-bit word read from the RAM
//   off  : byte offset of the access within the word
//   size : access size
//   uns  : 1 forces zero extension for byte/half loads
//   data : extended load result (0 for the illegal size)
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[8*off +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    data   = '0;
    unique case (size)
      SZ_BYTE: data = {{24{lane_b[7] & ~uns}}, lane_b};
      SZ_HALF: data = {{16{lane_h[15] & ~uns}}, lane_h};
      SZ_WORD: data = word;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Data memory with byte/half/word accesses, fault detection and a
// READ_LATENCY-deep request/response pipeline with valid/ready handshakes.
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid/req_ready    : request handshake
//   RW, address, size      : 1 = store; byte address; 00 b, 01 h, 10 w, 11 illegal
//   unsigned_ld, wdata     : zero-extend loads; LSB-justified store data
//   rsp_valid/rsp_ready    : response handshake
//   rdata, fault           : extended load data (0 for stores/faults); fault flag
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              RW,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [31:0]       wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rdata,
  output logic              fault
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  logic [31:0]     mem     [DEPTH_WORDS];
  stage_t          stage_q [READ_LATENCY];
  logic [31:0]     word_q  [READ_LATENCY];

  size_e           sz;
  logic [IdxW-1:0] idx;
  logic            out_of_range, misaligned, req_fault;
  logic            stall, accept;
  logic [3:0]      be;
  logic [31:0]     wrep;
  stage_t          in_stage, last;
  logic [31:0]     aligned;

  assign sz  = size_e'(size);
  assign idx = address[IdxW+1:2];

  // Any set bit above the word index is out of range; addresses never wrap.
  assign out_of_range = (address >> (IdxW + 2)) != '0;
  assign misaligned   = ((sz == SZ_HALF) && address[0]) ||
                        ((sz == SZ_WORD) && (address[1:0] != 2'b00));
  assign req_fault    = (sz == SZ_ILL) || misaligned || out_of_range;

  assign stall     = rsp_valid && !rsp_ready;
  assign req_ready = !rst && !stall;
  assign accept    = req_valid && req_ready;

  assign be = byte_en(sz, address[1:0]);

  always_comb begin
    wrep = wdata;
    unique case (sz)
      SZ_BYTE: wrep = {4{wdata[7:0]}};
      SZ_HALF: wrep = {2{wdata[15:0]}};
      default: wrep = wdata;
    endcase
  end

  always_comb begin
    in_stage       = '0;
    in_stage.valid = accept;
    in_stage.rw    = RW;
    in_stage.off   = address[1:0];
    in_stage.size  = sz;
    in_stage.uns   = unsigned_ld;
    in_stage.fault = req_fault;
  end

  // RAM write at the accept edge; not reset.
  always_ff @(posedge clk) begin
    if (accept && RW && !req_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  // Read data travels alongside its stage record; contents are meaningless
  // unless the matching valid bit is set, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (!stall) begin
      word_q[0] <= mem[idx];
      for (int i = 1; i < int'(READ_LATENCY); i++) word_q[i] <= word_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) stage_q[i] <= '0;
    end else if (!stall) begin
      stage_q[0] <= in_stage;
      for (int i = 1; i < int'(READ_LATENCY); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign last = stage_q[READ_LATENCY-1];

  dmem_load_align u_align (
    .word (word_q[READ_LATENCY-1]),
    .off  (last.off),
    .size (last.size),
    .uns  (last.uns),
    .data (aligned)
  );

  assign rsp_valid = last.valid;
  assign fault     = last.valid && last.fault;
  assign rdata     = (last.valid && !last.rw && !last.fault) ? aligned : '0;

endmodule

// File: tb/tb_dmem_sized.sv
// Randomised scoreboard bench for dmem_sized: a driver pushes expected
// responses from a byte-level reference model, a monitor pops and compares.
module tb_dmem_sized;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned LAT   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        rw = 1'b0;
  logic [31:0] address = '0;
  logic [1:0]  size = '0;
  logic        unsigned_ld = 1'b0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rdata;
  logic        fault;

  dmem_sized #(
    .DEPTH_WORDS  (DEPTH),
    .READ_LATENCY (LAT),
    .ADDR_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .RW          (rw),
    .address     (address),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .wdata       (wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rdata       (rdata),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        f;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mm [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          mode  = 0;  // 0: rsp_ready=1, 1: hold rsp_ready=0, 2: random

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as plain words, accesses via shifts and masks.
  function automatic bit mfault(logic [31:0] a, logic [1:0] sz);
    return (sz == 2'd3) || (a >= 32'(4 * DEPTH)) ||
           (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
  endfunction

  function automatic logic [31:0] mload(logic [31:0] a, logic [1:0] sz, bit uns);
    logic [31:0] w;
    logic [31:0] v;
    int          sh;
    w  = mm[a / 4];
    sh = 8 * int'(a % 4);
    if (sz == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = w;
    end
    return v;
  endfunction

  task automatic mstore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] mask;
    int          sh;
    sh   = 8 * int'(a % 4);
    mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    mask = mask << sh;
    mm[a / 4] = (mm[a / 4] & ~mask) | ((wd << sh) & mask);
  endtask

  // Drives one request; on acceptance pushes the expected response (a literal
  // if lit is set, otherwise the model's answer) and updates the model.
  task automatic issue(input bit r, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                       input logic [31:0] wd, input bit lit, input logic [31:0] lit_rd,
                       input bit lit_f, input string tag);
    int   waited;
    exp_t e;
    waited = 0;
    @(negedge clk);
    rw = r; address = a; size = sz; unsigned_ld = uns; wdata = wd; req_valid = 1'b1;
    #1;
    while (!req_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: request not accepted, req_ready=%b after %0d cycles", tag, req_ready, waited);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.tag = tag;
    if (mfault(a, sz)) begin
      e.rd = '0; e.f = 1'b1;
    end else if (r) begin
      e.rd = '0; e.f = 1'b0;
      mstore(a, sz, wd);
    end else begin
      e.rd = mload(a, sz, uns); e.f = 1'b0;
    end
    if (lit) begin
      e.rd = lit_rd; e.f = lit_f;
    end
    exp_q.push_back(e);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: sets rsp_ready for the coming edge, then checks the handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      case (mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'b0;
        default: rsp_ready = ($urandom_range(0, 3) != 0);
      endcase
      #1;
      if (!rst) begin
        chk("req_ready_rule", {31'b0, req_ready}, {31'b0, !(rsp_valid && !rsp_ready)});
        if (rsp_valid && rsp_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_rsp: got rdata=%h fault=%b, expected no response", rdata, fault);
          end else begin
            e = exp_q.pop_front();
            chk({e.tag, "_rdata"}, rdata, e.rd);
            chk({e.tag, "_fault"}, {31'b0, fault}, {31'b0, e.f});
          end
        end
      end
    end
  end

  initial begin
    int          k;
    logic [31:0] held;
    logic [31:0] a;
    logic [1:0]  sz;

    rst = 1'b1;
    #1;
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1 chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

    // Fill every word so the model is fully defined.
    for (int i = 0; i < int'(DEPTH); i++)
      issue(1'b1, 32'(4 * i), 2'd2, 1'b0, $urandom, 1'b0, '0, 1'b0, "fill");
    wait_drain("fill");

    // Word store/load with unstalled latency measurement.
    issue(1'b1, 32'h0, 2'd2, 1'b0, 32'hABCDEF00, 1'b1, 32'h0, 1'b0, "sw0");
    wait_drain("sw0");
    issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 32'hABCDEF00, 1'b0, "lw0");
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!rsp_valid && k < 20);
    chk("latency", 32'(k), 32'(LAT));
    wait_drain("lw0");

    // Byte and half lanes.
    issue(1'b1, 32'h4, 2'd2, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, "sw4");
    issue(1'b1, 32'h6, 2'd0, 1'b0, 32'h00000012, 1'b1, 32'h0, 1'b0, "sb6");
    issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1'b1, 32'hFF12FFFF, 1'b0, "lw4");
    issue(1'b0, 32'h6, 2'd0, 1'b0, 32'h0, 1'b1, 32'h00000012, 1'b0, "lb6");
    issue(1'b0, 32'h7, 2'd0, 1'b0, 32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, "lb7");
    issue(1'b0, 32'h7, 2'd0, 1'b1, 32'h0, 1'b1, 32'h000000FF, 1'b0, "lbu7");
    issue(1'b1, 32'hA, 2'd1, 1'b0, 32'h00008001, 1'b1, 32'h0, 1'b0, "sha");
    issue(1'b0, 32'hA, 2'd1, 1'b0, 32'h0, 1'b1, 32'hFFFF8001, 1'b0, "lha");
    issue(1'b0, 32'hA, 2'd1, 1'b1, 32'h0, 1'b1, 32'h00008001, 1'b0, "lhua");

    // Faults.
    issue(1'b0, 32'h2, 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, "lw2_mis");
    issue(1'b1, 32'h5, 2'd1, 1'b0, 32'h0000BEEF, 1'b1, 32'h0, 1'b1, "sh5_mis");
    issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1'b1, 32'hFF12FFFF, 1'b0, "lw4_after");
    issue(1'b0, 32'(4 * DEPTH), 2'd2, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, "lw_oor");
    issue(1'b1, 32'(4 * DEPTH) + 32'h8, 2'd2, 1'b0, 32'h1, 1'b1, 32'h0, 1'b1, "sw_oor");
    issue(1'b0, 32'h8, 2'd2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, "lw8_nowrap");
    issue(1'b0, 32'h8, 2'd3, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, "size_ill");
    wait_drain("directed");

    // Backpressure: fill the pipeline with rsp_ready held low.
    mode = 1;
    for (int i = 0; i < int'(LAT); i++)
      issue(1'b0, 32'(16 + 4 * i), 2'd2, 1'b0, 32'h0, 1'b0, '0, 1'b0, "bp_ld");
    @(negedge clk);
    #2;
    chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
    chk("bp_front", rdata, exp_q[0].rd);
    held = rdata;
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("bp_rdata_hold", rdata, held);
      chk("bp_req_ready_low", {31'b0, req_ready}, 32'd0);
    end
    mode = 0;
    wait_drain("bp");

    // Reset with loads in flight.
    mode = 1;
    for (int i = 0; i < int'(LAT); i++)
      issue(1'b0, 32'(32 + 4 * i), 2'd2, 1'b0, 32'h0, 1'b0, '0, 1'b0, "rst_ld");
    @(negedge clk);
    #2;
    chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    mode = 0;
    repeat (8) @(negedge clk);
    issue(1'b0, 32'h4, 2'd2, 1'b0, 32'h0, 1'b1, 32'hFF12FFFF, 1'b0, "persist4");
    issue(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 32'hABCDEF00, 1'b0, "persist0");
    wait_drain("persist");

    // Random traffic against the model with random backpressure.
    mode = 2;
    for (int i = 0; i < 400; i++) begin
      k  = int'($urandom_range(0, 9));
      sz = 2'($urandom_range(0, 3));
      if (k == 0)      a = $urandom | 32'h100;
      else if (k == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 4 * DEPTH - 1));
      if (k > 5 && sz != 2'd0) a = a & ~((sz == 2'd1) ? 32'h1 : 32'h3);
      issue(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
            1'b0, '0, 1'b0, "rand");
    end
    mode = 0;
    wait_drain("rand");
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
